// File: rtl/usr_pkg.sv
// Shared types and mode encodings for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_t;

endpackage

// File: rtl/usr_frame_cnt.sv
// Frame counter: counts shifts in either direction and pulses frame_done
// for one cycle after the WIDTH-th shift of a frame.
module usr_frame_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clr,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Load aborts the frame; holds leave the count paused where it is.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (shift) begin
            if (shift_cnt == LAST) begin
                shift_cnt  <= '0;
                frame_done <= 1'b1;
            end else begin
                shift_cnt  <= shift_cnt + 1'b1;
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// with frame counter. Optional registered parity output under USR_PARITY_EN.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             frame_done,
    output logic [CNT_W-1:0] shift_cnt
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    usr_mode_t        mode_e;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;

    assign mode_e = usr_mode_t'(mode);

    always_comb begin
        q_next = q;
        case (mode_e)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            MODE_LOAD: q_next = pin;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

`ifdef USR_PARITY_EN
    // Parity is taken from the next value so it tracks q with no extra latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ^q_next;
        end
    end
`endif

    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    usr_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .shift      ((mode_e == MODE_SHR) || (mode_e == MODE_SHL)),
        .clr        (mode_e == MODE_LOAD),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, plus WIDTH=5
// parity instance when USR_PARITY_EN is defined).
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  pin;
    logic [W-1:0]  pout;
    logic          sout_r;
    logic          sout_l;
    logic          frame_done;
    logic [CW-1:0] shift_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

`ifdef USR_PARITY_EN
    localparam int W5  = 5;
    localparam int CW5 = $clog2(W5 + 1);

    logic           parity8;
    logic [1:0]     mode5;
    logic           sin_r5;
    logic [W5-1:0]  pin5;
    logic [W5-1:0]  pout5;
    logic           sout_r5;
    logic           sout_l5;
    logic           frame_done5;
    logic [CW5-1:0] shift_cnt5;
    logic           parity5;

    univ_shift_reg #(.WIDTH(W5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode5),
        .sin_r      (sin_r5),
        .sin_l      (1'b0),
        .pin        (pin5),
        .pout       (pout5),
        .sout_r     (sout_r5),
        .sout_l     (sout_l5),
        .frame_done (frame_done5),
        .shift_cnt  (shift_cnt5),
        .parity     (parity5)
    );
`endif

    univ_shift_reg #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .frame_done (frame_done),
        .shift_cnt  (shift_cnt)
`ifdef USR_PARITY_EN
        ,
        .parity     (parity8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] value);
        mode = 2'b11;
        pin  = value;
        tick();
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        mode = 2'b11;
        pin  = 8'hFF;
        tick();
        tick();
        checks++;
        if (pout !== 8'h00) $display("[TB] FAIL reset_pout got=%h exp=00", pout);
        else passed++;
        checks++;
        if (sout_r !== 1'b0 || sout_l !== 1'b0)
            $display("[TB] FAIL reset_sout got=%b%b exp=00", sout_r, sout_l);
        else passed++;
        checks++;
        if (shift_cnt !== '0 || frame_done !== 1'b0)
            $display("[TB] FAIL reset_cnt got cnt=%0d fd=%b exp cnt=0 fd=0", shift_cnt, frame_done);
        else passed++;
        rst = 1'b1;
        tick();
        checks++;
        if (pout !== 8'hFF) $display("[TB] FAIL reset_release_load got=%h exp=ff", pout);
        else passed++;
    endtask

    task automatic test_siso_right();
        logic [7:0] seq;
        seq = 8'b0100_1101;
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        mode = 2'b01;
        sin_l = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sin_r = seq[k];
            tick();
            if (k < 7) begin
                checks++;
                if (frame_done !== 1'b0 || shift_cnt !== CW'(k + 1))
                    $display("[TB] FAIL siso_cnt edge=%0d got cnt=%0d fd=%b exp cnt=%0d fd=0",
                             k + 1, shift_cnt, frame_done, k + 1);
                else passed++;
            end
        end
        checks++;
        if (pout !== 8'b0100_1101) $display("[TB] FAIL siso_pout got=%b exp=01001101", pout);
        else passed++;
        checks++;
        if (frame_done !== 1'b1 || shift_cnt !== '0)
            $display("[TB] FAIL siso_frame_done got fd=%b cnt=%0d exp fd=1 cnt=0", frame_done, shift_cnt);
        else passed++;
        // Replay: sout_r presents the input sequence, first bit after edge 8.
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sout_r !== seq[k])
                $display("[TB] FAIL siso_replay idx=%0d got=%b exp=%b", k, sout_r, seq[k]);
            else passed++;
            sin_r = 1'b0;
            tick();
            if (k == 0) begin
                checks++;
                if (frame_done !== 1'b0) $display("[TB] FAIL siso_pulse_width got=%b exp=0", frame_done);
                else passed++;
            end
        end
        checks++;
        if (frame_done !== 1'b1) $display("[TB] FAIL back_to_back_frame got=%b exp=1", frame_done);
        else passed++;
    endtask

    task automatic test_piso_left();
        logic [7:0] exp_bits;
        int         pulses;
        exp_bits = 8'b1010_0101;
        pulses   = 0;
        do_load(8'hA5);
        mode  = 2'b10;
        sin_l = 1'b0;
        sin_r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sout_l !== exp_bits[7 - k])
                $display("[TB] FAIL piso_sout_l idx=%0d got=%b exp=%b", k, sout_l, exp_bits[7 - k]);
            else passed++;
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (pout !== 8'h00) $display("[TB] FAIL piso_pout got=%h exp=00", pout);
        else passed++;
        mode = 2'b00;
        tick();
        if (frame_done === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) $display("[TB] FAIL piso_pulses got=%0d exp=1", pulses);
        else passed++;
    endtask

    task automatic test_hold_mix();
        do_load(8'h00);
        mode  = 2'b01;
        sin_r = 1'b1;
        repeat (3) tick();
        mode = 2'b00;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (shift_cnt !== CW'(3) || frame_done !== 1'b0 || pout !== 8'hE0)
                $display("[TB] FAIL mix_hold idx=%0d got cnt=%0d fd=%b q=%h exp cnt=3 fd=0 q=e0",
                         k, shift_cnt, frame_done, pout);
            else passed++;
        end
        mode  = 2'b10;
        sin_l = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                checks++;
                if (frame_done !== 1'b0)
                    $display("[TB] FAIL mix_early_done idx=%0d got=1 exp=0", k);
                else passed++;
            end
        end
        checks++;
        if (frame_done !== 1'b1 || shift_cnt !== '0 || pout !== 8'h1F)
            $display("[TB] FAIL mix_done got fd=%b cnt=%0d q=%h exp fd=1 cnt=0 q=1f",
                     frame_done, shift_cnt, pout);
        else passed++;
        sin_l = 1'b0;
        repeat (2) tick();
        checks++;
        if (shift_cnt !== CW'(2) || pout !== 8'h7C || frame_done !== 1'b0)
            $display("[TB] FAIL mix_end got cnt=%0d q=%h fd=%b exp cnt=2 q=7c fd=0",
                     shift_cnt, pout, frame_done);
        else passed++;
    endtask

    task automatic test_load_abort();
        int pulses;
        pulses = 0;
        do_load(8'h00);
        mode  = 2'b01;
        sin_r = 1'b0;
        repeat (5) tick();
        do_load(8'h3C);
        checks++;
        if (shift_cnt !== '0 || pout !== 8'h3C || frame_done !== 1'b0)
            $display("[TB] FAIL load_abort got cnt=%0d q=%h fd=%b exp cnt=0 q=3c fd=0",
                     shift_cnt, pout, frame_done);
        else passed++;
        mode = 2'b01;
        repeat (3) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || shift_cnt !== CW'(3))
            $display("[TB] FAIL load_restart got pulses=%0d cnt=%0d exp pulses=0 cnt=3", pulses, shift_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_load(8'h00);
        mode  = 2'b01;
        sin_r = 1'b1;
        repeat (6) tick();
        checks++;
        if (pout !== 8'hFC || shift_cnt !== CW'(6))
            $display("[TB] FAIL pre_reset got q=%h cnt=%0d exp q=fc cnt=6", pout, shift_cnt);
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if (pout !== 8'h00 || sout_r !== 1'b0 || sout_l !== 1'b0 || shift_cnt !== '0 || frame_done !== 1'b0)
            $display("[TB] FAIL reset_mid got q=%h sr=%b sl=%b cnt=%0d fd=%b exp all 0",
                     pout, sout_r, sout_l, shift_cnt, frame_done);
        else passed++;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (shift_cnt !== CW'(2) || frame_done !== 1'b0 || pout !== 8'hC0)
            $display("[TB] FAIL reset_resume got cnt=%0d fd=%b q=%h exp cnt=2 fd=0 q=c0",
                     shift_cnt, frame_done, pout);
        else passed++;
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        rst   = 1'b0;
        mode5 = 2'b11;
        pin5  = 5'b11111;
        tick();
        checks++;
        if (parity5 !== 1'b0) $display("[TB] FAIL parity_reset got=%b exp=0", parity5);
        else passed++;
        rst = 1'b1;
        pin5 = 5'b10110;
        tick();
        checks++;
        if (parity5 !== 1'b1 || pout5 !== 5'b10110)
            $display("[TB] FAIL parity_load1 got p=%b q=%b exp p=1 q=10110", parity5, pout5);
        else passed++;
        mode5  = 2'b01;
        sin_r5 = 1'b0;
        tick();
        checks++;
        if (parity5 !== 1'b1 || pout5 !== 5'b01011)
            $display("[TB] FAIL parity_shift got p=%b q=%b exp p=1 q=01011", parity5, pout5);
        else passed++;
        mode5 = 2'b11;
        pin5  = 5'b00011;
        tick();
        checks++;
        if (parity5 !== 1'b0 || pout5 !== 5'b00011)
            $display("[TB] FAIL parity_load2 got p=%b q=%b exp p=0 q=00011", parity5, pout5);
        else passed++;
    endtask
`endif

    initial begin
        rst   = 1'b0;
        mode  = 2'b00;
        sin_r = 1'b0;
        sin_l = 1'b0;
        pin   = '0;
`ifdef USR_PARITY_EN
        mode5  = 2'b00;
        sin_r5 = 1'b0;
        pin5   = '0;
`endif
        #2;
        test_reset();
        test_siso_right();
        test_piso_left();
        test_hold_mix();
        test_load_abort();
        test_reset_mid();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; the successor to the fixed 1-bit serial-in/serial-out register.
- Supports four per-cycle modes: hold, shift right, shift left, parallel load.
- Serial outputs exist for both directions, plus a registered parallel output.
- A frame counter flags completion of WIDTH consecutive shifts. Intended for serialiser/deserialiser datapaths (SISO, SIPO, PISO and PIPO use in one block).

Parameters:
- WIDTH, 8, register length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), frame counter width; derived, not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset; sampled only on rising clk
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sin_r  input  1  serial in for shift right; enters bit WIDTH-1
- sin_l  input  1  serial in for shift left; enters bit 0
- pin  input  WIDTH  parallel load data
- pout  output  WIDTH  register contents q
- sout_r  output  1  q[0]; serial out for shift right
- sout_l  output  1  q[WIDTH-1]; serial out for shift left
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame
- shift_cnt  output  CNT_W  shifts completed in the current frame

Behaviour:
- Reset: rst==0 at a rising edge sets q=0, shift_cnt=0, frame_done=0, which forces sout_r=0 and sout_l=0. Reset overrides every mode, including a reset asserted mid-frame (counter clears). With rst==0, inputs are ignored.
- Hold (00): q, shift_cnt unchanged; frame_done=0.
- Shift right (01): q <= {sin_r, q[WIDTH-1:1]}.
- Shift left (10): q <= {q[WIDTH-2:0], sin_l}.
- Load (11): q <= pin; shift_cnt <= 0; frame_done <= 0.
- pout, sout_r and sout_l are direct taps of the register, so they have zero combinational logic from inputs. A bit presented at sin_r appears on sout_r after exactly WIDTH shift-right edges.
- Counter, per shift (either direction):
  - If shift_cnt==WIDTH-1: shift_cnt <= 0 and frame_done <= 1 on that same edge.
  - Otherwise: shift_cnt <= shift_cnt+1 and frame_done <= 0.
- frame_done is therefore high for exactly the one cycle following the completing edge.
- A direction change mid-frame does not reset the counter; shifts in both directions count toward the frame.
- Hold cycles pause the counter; the frame continues afterwards.
- Load mid-frame aborts the frame (counter to 0, no frame_done).
- Back-to-back frames: with continuous shifting, frame_done pulses every WIDTH cycles.
- No X propagation from unused serial inputs: sin_l is don't-care during shift right, and sin_r during shift left.

Optional Feature:
- Macro USR_PARITY_EN.
- When defined: extra output port parity (1 bit) = registered XOR-reduction of the next value of q. It therefore equals ^q every cycle, including after reset (0). It updates on the same edge as q, so it adds no extra latency.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package usr_pkg holds:
  - typedef usr_mode_t (2-bit enum)
  - constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
- One sub-module, usr_frame_cnt: implements the shift counter and frame_done pulse. Inputs are clk, rst, shift (mode is SHR or SHL), clr (mode is LOAD); parameter WIDTH. The top instantiates it once.

Test Plan (WIDTH=8 unless noted):
- Reset: hold rst=0 for 2 edges while mode=11, pin=8'hFF. Required: pout=8'h00, sout_r=0, sout_l=0, shift_cnt=0, frame_done=0. Release rst, next edge loads 8'hFF.
- SISO right: from reset, mode=01, drive sin_r=1,0,1,1,0,0,1,0 over 8 edges. Required: pout=8'b0100_1101 after edge 8. frame_done is high only in the cycle after edge 8, and sout_r replays the input sequence starting at edge 8.
- PISO left: load pin=8'hA5, then 8 edges with mode=10, sin_l=0. Required: sout_l sequence before each edge is 1,0,1,0,0,1,0,1; final pout=8'h00; frame_done pulses once.
- Hold/direction mix: 3 shifts right, 2 holds, 5 shifts left. Required: shift_cnt is 3 during the holds, frame_done pulses after the 8th shift, and shift_cnt=2 at the end.
- Load abort and reset mid-frame:
  - After 5 shifts, mode=11 with pin=8'h3C. Required: shift_cnt=0, pout=8'h3C, no frame_done.
  - Separately, rst=0 after 6 shifts. Required: all outputs clear, no frame_done.
- Parity (USR_PARITY_EN, WIDTH=5): load 5'b10110 gives parity=1; one shift right with sin_r=0 gives q=5'b01011 and parity=1; load 5'b00011 gives parity=0.
